// File: rtl/conv_bus_pkg.sv
// Shared types and default widths for the conv bus arbiter and its beat tracker.
package conv_bus_pkg;

  localparam int LEN_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 255;
  localparam int TO_W_DEF    = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_DATA = 3'd4
  } arb_state_t;

  function automatic logic is_rd_state(arb_state_t s);
    return (s == S_RD_ADDR) || (s == S_RD_DATA);
  endfunction

  function automatic logic is_wr_state(arb_state_t s);
    return (s == S_WR_ADDR) || (s == S_WR_DATA);
  endfunction

endpackage

// File: rtl/conv_bus_arb_if.sv
// Request/handshake bundle between the read/write requesters, the bus and the arbiter.
interface conv_bus_arb_if
  import conv_bus_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
);

  logic             rd_req;
  logic [LEN_W-1:0] rd_len;
  logic             arready;
  logic             rvalid;
  logic             rlast;
  logic             wr_req;
  logic [LEN_W-1:0] wr_len;
  logic             awready;
  logic             wready;
  logic             wuser_last;
  logic             grant_rd;
  logic             grant_wr;

  modport master (
    input  rd_req, rd_len, arready, rvalid, rlast,
    input  wr_req, wr_len, awready, wready, wuser_last,
    output grant_rd, grant_wr
  );

  modport slave (
    output rd_req, rd_len, arready, rvalid, rlast,
    output wr_req, wr_len, awready, wready, wuser_last,
    input  grant_rd, grant_wr
  );

endinterface

// File: rtl/conv_beat_tracker.sv
// Beat counter and no-handshake watchdog, shared by whichever burst currently owns the bus.
module conv_beat_tracker
  import conv_bus_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active_i,
  input  logic             start_i,
  input  logic             beat_i,
  input  logic             last_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             done_o,
  output logic             len_err_o,
  output logic             timeout_o
);

  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [TO_W-1:0]  wdog_q, wdog_d;
  logic             end_cnt;
  logic             hs;
  logic             wdog_hit;
  logic             wdog_sat;

  // The compare sees the count before this beat is added.
  assign end_cnt   = (cnt_q == len_q);
  assign done_o    = beat_i & (last_i | end_cnt);
  assign len_err_o = beat_i & ~last_i & end_cnt;

  // A handshake in the expiring cycle keeps the burst alive.
  assign hs        = start_i | beat_i;
  assign wdog_hit  = (wdog_q == TO_W'(TIMEOUT - 1));
  assign wdog_sat  = (wdog_q == TO_W'(TIMEOUT));
  assign timeout_o = active_i & ~hs & wdog_hit;

  always_comb begin
    cnt_d  = cnt_q;
    len_d  = len_q;
    wdog_d = wdog_q;
    if (start_i) begin
      len_d = len_i;
      cnt_d = '0;
    end else if (beat_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + LEN_W'(1);
    end
    // Held at zero while idle, so every burst starts with a fresh watchdog.
    if (!active_i || hs) begin
      wdog_d = '0;
    end else if (!wdog_sat) begin
      wdog_d = wdog_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      len_q  <= '0;
      wdog_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      wdog_q <= wdog_d;
    end
  end

endmodule

// File: rtl/conv_bus_arb.sv
// Read/write bus arbiter: grants one burst at a time, alternates under contention, aborts hung bursts.
module conv_bus_arb
  import conv_bus_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arb_en,
  input  logic                  err_clr,
  conv_bus_arb_if.master        bus,
  output logic                  busy,
  output logic                  err_to,
  output logic                  err_len
);

  arb_state_t       state_q, state_d;
  logic             last_rd_q, last_rd_d;
  logic             err_to_q, err_to_d;
  logic             err_len_q, err_len_d;
  logic             set_to, set_len;

  logic             rd_ahs, wr_ahs;
  logic             trk_active, trk_start, trk_beat, trk_last;
  logic [LEN_W-1:0] trk_len;
  logic             trk_done, trk_len_err, trk_timeout;

  assign rd_ahs     = (state_q == S_RD_ADDR) & bus.rd_req & bus.arready;
  assign wr_ahs     = (state_q == S_WR_ADDR) & bus.wr_req & bus.awready;
  assign trk_active = (state_q != S_IDLE);
  assign trk_start  = rd_ahs | wr_ahs;
  assign trk_beat   = ((state_q == S_RD_DATA) & bus.rvalid) |
                      ((state_q == S_WR_DATA) & bus.wready);
  assign trk_last   = (state_q == S_RD_DATA) ? bus.rlast  : bus.wuser_last;
  assign trk_len    = (state_q == S_RD_ADDR) ? bus.rd_len : bus.wr_len;

  conv_beat_tracker #(
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_trk (
    .clk       (clk),
    .rst_n     (rst_n),
    .active_i  (trk_active),
    .start_i   (trk_start),
    .beat_i    (trk_beat),
    .last_i    (trk_last),
    .len_i     (trk_len),
    .done_o    (trk_done),
    .len_err_o (trk_len_err),
    .timeout_o (trk_timeout)
  );

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    set_to    = 1'b0;
    set_len   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_en) begin
          if (bus.rd_req && bus.wr_req) begin
            state_d = last_rd_q ? S_WR_ADDR : S_RD_ADDR;
          end else if (bus.rd_req) begin
            state_d = S_RD_ADDR;
          end else if (bus.wr_req) begin
            state_d = S_WR_ADDR;
          end
        end
      end
      S_RD_ADDR: begin
        if (rd_ahs) begin
          state_d = S_RD_DATA;
        end else if (!bus.rd_req) begin
          state_d = S_IDLE;
        end else if (trk_timeout) begin
          state_d   = S_IDLE;
          last_rd_d = 1'b1;
          set_to    = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (trk_done || trk_timeout) begin
          state_d   = S_IDLE;
          last_rd_d = 1'b1;
          set_len   = trk_len_err;
          set_to    = trk_timeout;
        end
      end
      S_WR_ADDR: begin
        if (wr_ahs) begin
          state_d = S_WR_DATA;
        end else if (!bus.wr_req) begin
          state_d = S_IDLE;
        end else if (trk_timeout) begin
          state_d   = S_IDLE;
          last_rd_d = 1'b0;
          set_to    = 1'b1;
        end
      end
      S_WR_DATA: begin
        if (trk_done || trk_timeout) begin
          state_d   = S_IDLE;
          last_rd_d = 1'b0;
          set_len   = trk_len_err;
          set_to    = trk_timeout;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A new error in the same cycle as a clear must not be lost.
  assign err_to_d  = set_to  | (err_to_q  & ~err_clr);
  assign err_len_d = set_len | (err_len_q & ~err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      last_rd_q <= 1'b0;
      err_to_q  <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      err_to_q  <= err_to_d;
      err_len_q <= err_len_d;
    end
  end

  assign bus.grant_rd = is_rd_state(state_q);
  assign bus.grant_wr = is_wr_state(state_q);
  assign busy         = (state_q != S_IDLE);
  assign err_to       = err_to_q;
  assign err_len      = err_len_q;

endmodule

// File: tb/tb_conv_bus_arb.sv
// Scoreboard bench for conv_bus_arb: stimulus queues expected output vectors, a monitor checks each change.
module tb_conv_bus_arb;
  import conv_bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arb_en, err_clr;
  logic busy, err_to, err_len;

  conv_bus_arb_if #(.LEN_W(4)) bus ();

  conv_bus_arb #(.LEN_W(4), .TIMEOUT(255), .TO_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_en  (arb_en),
    .err_clr (err_clr),
    .bus     (bus),
    .busy    (busy),
    .err_to  (err_to),
    .err_len (err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  // vector = {grant_rd, grant_wr, busy, err_to, err_len}
  logic [4:0] exp_q[$];
  logic [4:0] mon_prev = 5'b0;
  logic [4:0] mon_v;

  function automatic logic [4:0] obs();
    return {bus.grant_rd, bus.grant_wr, busy, err_to, err_len};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every change of the output vector must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      mon_v = obs();
      if (mon_v !== mon_prev) begin
        if (exp_q.size() == 0) chk("sb_unexpected_change", {27'b0, mon_v}, {27'b0, mon_prev});
        else                   chk("sb_out", {27'b0, mon_v}, {27'b0, exp_q.pop_front()});
        mon_prev = mon_v;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit");
    $fatal(1);
  end

  initial begin
    int n;
    arb_en = 1'b1; err_clr = 1'b0;
    bus.rd_req = 0; bus.rd_len = '0; bus.arready = 0; bus.rvalid = 0; bus.rlast = 0;
    bus.wr_req = 0; bus.wr_len = '0; bus.awready = 0; bus.wready = 0; bus.wuser_last = 0;
    repeat (3) cyc();
    chk("reset_outputs", {27'b0, obs()}, 32'h0);
    rst_n = 1'b1;
    cyc();

    // Lone read, len=3, arready one cycle late, rlast on beat 4.
    bus.rd_req = 1; bus.rd_len = 4'd3;
    exp_q.push_back(5'b10100);
    cyc();
    chk("t2_grant_latency", {31'b0, bus.grant_rd}, 32'h1);
    cyc();
    bus.arready = 1;
    cyc();
    bus.arready = 0; bus.rd_req = 0; bus.rvalid = 1;
    repeat (3) cyc();
    chk("t2_grant_held", {31'b0, bus.grant_rd}, 32'h1);
    bus.rlast = 1;
    exp_q.push_back(5'b00000);
    cyc();
    bus.rvalid = 0; bus.rlast = 0;
    chk("t2_idle_after_last", {27'b0, obs()}, 32'h0);
    cyc();

    // Asynchronous reset in the middle of a read data phase.
    bus.rd_req = 1; bus.rd_len = 4'd3;
    exp_q.push_back(5'b10100);
    cyc();
    bus.arready = 1;
    cyc();
    bus.arready = 0; bus.rvalid = 1;
    cyc();
    exp_q.push_back(5'b00000);
    #2 rst_n = 1'b0;
    #1 chk("t1_async_reset", {27'b0, obs()}, 32'h0);
    bus.rvalid = 0; bus.rd_req = 0;
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("t1_idle_after_reset", {31'b0, busy}, 32'h0);

    // Both requesting continuously, len=0: RD, WR, RD, WR with idle gaps.
    exp_q.push_back(5'b10100); exp_q.push_back(5'b00000);
    exp_q.push_back(5'b01100); exp_q.push_back(5'b00000);
    exp_q.push_back(5'b10100); exp_q.push_back(5'b00000);
    exp_q.push_back(5'b01100); exp_q.push_back(5'b00000);
    bus.rd_req = 1; bus.wr_req = 1; bus.rd_len = 0; bus.wr_len = 0;
    bus.arready = 1; bus.awready = 1; bus.rvalid = 1; bus.rlast = 1;
    bus.wready = 1; bus.wuser_last = 1;
    repeat (12) cyc();
    bus.rd_req = 0; bus.wr_req = 0; bus.arready = 0; bus.awready = 0;
    bus.rvalid = 0; bus.rlast = 0; bus.wready = 0; bus.wuser_last = 0;
    cyc();
    chk("t3_idle_end", {31'b0, busy}, 32'h0);

    // Write len=1 with no last flag: ends after beat 2 with err_len.
    bus.wr_req = 1; bus.wr_len = 4'd1;
    exp_q.push_back(5'b01100);
    cyc();
    bus.awready = 1;
    cyc();
    bus.awready = 0; bus.wr_req = 0; bus.wready = 1;
    cyc();
    chk("t4_after_beat1", {31'b0, bus.grant_wr}, 32'h1);
    exp_q.push_back(5'b00001);
    cyc();
    bus.wready = 0;
    chk("t4_err_len_set", {31'b0, err_len}, 32'h1);
    err_clr = 1;
    exp_q.push_back(5'b00000);
    cyc();
    err_clr = 0;
    chk("t4_err_len_clr", {31'b0, err_len}, 32'h0);

    // Length error in the same cycle as err_clr: the set wins.
    bus.wr_req = 1; bus.wr_len = 4'd0;
    exp_q.push_back(5'b01100);
    cyc();
    bus.awready = 1;
    cyc();
    bus.awready = 0; bus.wr_req = 0; bus.wready = 1; err_clr = 1;
    exp_q.push_back(5'b00001);
    cyc();
    bus.wready = 0; err_clr = 0;
    chk("t4_set_beats_clr", {31'b0, err_len}, 32'h1);
    err_clr = 1;
    exp_q.push_back(5'b00000);
    cyc();
    err_clr = 0;

    // Read granted but arready never comes: watchdog abort, then pending write is served.
    bus.rd_req = 1; bus.rd_len = 0;
    exp_q.push_back(5'b10100); exp_q.push_back(5'b00010);
    exp_q.push_back(5'b01110); exp_q.push_back(5'b00010);
    exp_q.push_back(5'b00000);
    cyc();
    bus.wr_req = 1;
    n = 0;
    while (bus.grant_rd === 1'b1 && n < 400) begin
      n++;
      cyc();
    end
    chk("t5_grant_cycles", n, 32'd255);
    chk("t5_err_to", {31'b0, err_to}, 32'h1);
    cyc();
    chk("t5_wr_granted", {31'b0, bus.grant_wr}, 32'h1);
    bus.rd_req = 0; bus.wr_req = 0;
    cyc();
    err_clr = 1;
    cyc();
    err_clr = 0;
    chk("t5_err_to_clr", {31'b0, err_to}, 32'h0);

    // arb_en dropped mid-burst: burst finishes, no new grant until re-enabled.
    bus.rd_req = 1; bus.rd_len = 4'd1;
    exp_q.push_back(5'b10100);
    cyc();
    bus.arready = 1;
    cyc();
    bus.arready = 0; arb_en = 0; bus.rvalid = 1;
    cyc();
    bus.rlast = 1;
    exp_q.push_back(5'b00000);
    cyc();
    bus.rvalid = 0; bus.rlast = 0;
    repeat (5) begin
      cyc();
      chk("t6_no_grant_disabled", {31'b0, bus.grant_rd}, 32'h0);
    end
    arb_en = 1;
    exp_q.push_back(5'b10100);
    cyc();
    chk("t6_grant_reenabled", {31'b0, bus.grant_rd}, 32'h1);
    bus.rd_req = 0;
    exp_q.push_back(5'b00000);
    cyc();
    cyc();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
